spi_xfer_seq: RTL and testbench

Multi-byte SPI transaction sequencer that sits directly upstream of the `spi_master` byte engine. It accepts a transaction length from the host, owns chip-select timing, and feeds transmit bytes to the byte engine one at a time via its `din`/`start`/`busy` handshake. It captures each received byte from the engine's `dout` and emits it on a receive strobe. Everything runs in the `clk4` domain shared with the byte engine.

---
 rtl/spi_xfer_seq_if.sv | 42 ++++
 rtl/spi_xfer_seq.sv | 152 +++++++++++++++
 tb/tb_spi_xfer_seq.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_xfer_seq_if.sv
// Bundle of the host command/transmit/receive handshakes and the byte-engine
// link used by spi_xfer_seq.
//   slave  : the sequencer side (takes commands and tx bytes, drives cs_n and
//            the byte-engine start/din, reports rx bytes and done)
//   master : the host plus byte-engine side
// Signals:
//   cmd_valid/cmd_len/cmd_ready   transaction request handshake
//   tx_data/tx_valid/tx_ready     transmit byte handshake
//   rx_data/rx_valid              received byte strobe (no backpressure)
//   done                          end-of-transaction strobe
//   cs_n                          SPI chip select, active-low
//   spi_din/spi_start/spi_busy/spi_dout   byte-engine link
interface spi_xfer_seq_if #(
    parameter int LEN_W = 8
) ();
    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             done;
    logic             cs_n;
    logic [7:0]       spi_din;
    logic             spi_start;
    logic             spi_busy;
    logic [7:0]       spi_dout;

    modport slave (
        input  cmd_valid, cmd_len, tx_data, tx_valid, spi_busy, spi_dout,
        output cmd_ready, tx_ready, rx_data, rx_valid, done, cs_n,
               spi_din, spi_start
    );

    modport master (
        output cmd_valid, cmd_len, tx_data, tx_valid, spi_busy, spi_dout,
        input  cmd_ready, tx_ready, rx_data, rx_valid, done, cs_n,
               spi_din, spi_start
    );
endinterface

// File: rtl/spi_xfer_seq.sv
// Multi-byte SPI transaction sequencer in front of the spi_master byte engine.
// Accepts a byte count, drops cs_n, waits CS_SETUP cycles, then feeds bytes
// one at a time to the engine via start/busy, returning each completed byte
// on rx_data/rx_valid. After the last byte it holds cs_n low CS_HOLD cycles,
// raises cs_n with a done strobe, and keeps cs_n high at least CS_IDLE
// cycles before accepting the next command.
// Ports:
//   clk4     single clock, shared with the byte engine (4x SPI clock)
//   reset_n  asynchronous active-low reset
//   bus      spi_xfer_seq_if slave modport (host handshakes + engine link)
module spi_xfer_seq #(
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4,
    parameter int LEN_W    = 8
) (
    input  logic          clk4,
    input  logic          reset_n,
    spi_xfer_seq_if.slave bus
);
    localparam int MAX_A  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int MAX_CS = (MAX_A > CS_IDLE) ? MAX_A : CS_IDLE;
    localparam int CNT_W  = $clog2(MAX_CS + 1);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

    typedef enum logic [2:0] {
        IDLE, SETUP, WAIT_TX, START, XFER, HOLD, GAP
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [LEN_W-1:0] rem, rem_nx;
    logic             cs_n_q, cs_n_nx;
    logic             start_q, start_nx;
    logic [7:0]       din_q, din_nx;
    logic [7:0]       rxd_q, rxd_nx;
    logic             rxv_q, rxv_nx;
    logic             done_q, done_nx;
    logic             cmd_ready_c, tx_ready_c;

    always_ff @(posedge clk4 or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            rem     <= '0;
            cs_n_q  <= 1'b1;
            start_q <= 1'b0;
            din_q   <= '0;
            rxd_q   <= '0;
            rxv_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            rem     <= rem_nx;
            cs_n_q  <= cs_n_nx;
            start_q <= start_nx;
            din_q   <= din_nx;
            rxd_q   <= rxd_nx;
            rxv_q   <= rxv_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        rem_nx      = rem;
        cs_n_nx     = cs_n_q;
        start_nx    = start_q;
        din_nx      = din_q;
        rxd_nx      = rxd_q;
        rxv_nx      = 1'b0;
        done_nx     = 1'b0;
        cmd_ready_c = 1'b0;
        tx_ready_c  = 1'b0;
        unique case (state)
            IDLE: begin
                // The engine has no reset: a byte left in flight by a reset
                // must drain before a new transaction may start.
                cmd_ready_c = !bus.spi_busy;
                if (bus.cmd_valid && !bus.spi_busy) begin
                    if (bus.cmd_len == '0) begin
                        done_nx = 1'b1;
                    end else begin
                        rem_nx   = bus.cmd_len;
                        cs_n_nx  = 1'b0;
                        cnt_nx   = CNT_W'(CS_SETUP);
                        state_nx = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_nx = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_nx = WAIT_TX;
            end
            WAIT_TX: begin
                tx_ready_c = 1'b1;
                if (bus.tx_valid) begin
                    din_nx   = bus.tx_data;
                    start_nx = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                // Hold start until the engine acknowledges with busy.
                if (bus.spi_busy) begin
                    start_nx = 1'b0;
                    state_nx = XFER;
                end
            end
            XFER: begin
                if (!bus.spi_busy) begin
                    rxd_nx = bus.spi_dout;
                    rxv_nx = 1'b1;
                    rem_nx = rem - REM_ONE;
                    if (rem == REM_ONE) begin
                        cnt_nx   = CNT_W'(CS_HOLD);
                        state_nx = HOLD;
                    end else begin
                        state_nx = WAIT_TX;
                    end
                end
            end
            HOLD: begin
                cnt_nx = cnt - CNT_ONE;
                if (cnt == CNT_ONE) begin
                    cs_n_nx  = 1'b1;
                    done_nx  = 1'b1;
                    cnt_nx   = CNT_W'(CS_IDLE);
                    state_nx = GAP;
                end
            end
            GAP: begin
                cnt_nx = cnt - CNT_ONE;
                if (cnt == CNT_ONE) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.tx_ready  = tx_ready_c;
    assign bus.rx_data   = rxd_q;
    assign bus.rx_valid  = rxv_q;
    assign bus.done      = done_q;
    assign bus.cs_n      = cs_n_q;
    assign bus.spi_din   = din_q;
    assign bus.spi_start = start_q;
endmodule

// File: tb/tb_spi_xfer_seq.sv
// Directed plus randomized bench for spi_xfer_seq against a behavioural
// byte-engine model (start -> busy for 32 cycles -> dout = din ^ eng_key).
module tb_spi_xfer_seq;
    localparam int S  = 4;
    localparam int H  = 4;
    localparam int I  = 4;
    localparam int LW = 8;

    logic clk4 = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   ncmp = 0;
    int   nfail = 0;

    spi_xfer_seq_if #(.LEN_W(LW)) bus ();

    spi_xfer_seq #(
        .CS_SETUP(S),
        .CS_HOLD (H),
        .CS_IDLE (I),
        .LEN_W   (LW)
    ) dut (
        .clk4   (clk4),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk4 = ~clk4;
    always @(posedge clk4) cyc <= cyc + 1;

    // Byte engine model: no reset, start accepted only when idle.
    logic       eng_busy = 1'b0;
    logic [7:0] eng_sr   = 8'h00;
    logic [7:0] eng_dout = 8'h00;
    logic [7:0] eng_key  = 8'h00;
    int         eng_cnt  = 0;
    always @(posedge clk4) begin
        if (eng_busy) begin
            if (eng_cnt == 1) begin
                eng_busy <= 1'b0;
                eng_dout <= eng_sr ^ eng_key;
            end
            eng_cnt <= eng_cnt - 1;
        end else if (bus.spi_start) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 32;
            eng_sr   <= bus.spi_din;
        end
    end
    assign bus.spi_busy = eng_busy;
    assign bus.spi_dout = eng_dout;

    // Output monitor (samples on the falling edge).
    logic [7:0] rxq_d[$];
    int         rxq_c[$];
    int         done_n = 0, done_c = 0;
    int         rise_n = 0, rise_c = 0, fall_n = 0;
    int         start_n = 0;
    logic       cs_prev = 1'b1;
    always @(negedge clk4) begin
        if (bus.rx_valid) begin
            rxq_d.push_back(bus.rx_data);
            rxq_c.push_back(cyc);
        end
        if (bus.done) begin
            done_n = done_n + 1;
            done_c = cyc;
        end
        if (bus.cs_n && !cs_prev) begin
            rise_n = rise_n + 1;
            rise_c = cyc;
        end
        if (!bus.cs_n && cs_prev) fall_n = fall_n + 1;
        cs_prev = bus.cs_n;
        if (bus.spi_start) start_n = start_n + 1;
    end

    logic [7:0] pat[$];

    task automatic tick();
        @(negedge clk4);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction of len bytes from pat; byte stall_at (if >0) is held
    // back stall_len cycles after tx_ready rises.
    task automatic do_xfer(input int len, input int stall_at, input int stall_len);
        int hs[$];
        int e, t, budget, rx0, dn0, rs0, fl0, rdy_c, last_r, bad, nrx;
        rx0 = rxq_d.size();
        dn0 = done_n;
        rs0 = rise_n;
        fl0 = fall_n;
        bus.cmd_len   = LW'(len);
        bus.cmd_valid = 1'b1;
        budget = 0;
        while (!bus.cmd_ready && budget < 2000) begin tick(); budget++; end
        chk("cmd_accept_wait", budget < 2000, 1);
        e = cyc;
        chk("cs_n_before_cmd", bus.cs_n, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("cs_n_after_cmd", bus.cs_n, 0);
        bus.tx_valid = 1'b1;
        bus.tx_data  = pat[0];
        for (int i = 0; i < len; i++) begin
            if (i == stall_at && i > 0) begin
                bus.tx_valid = 1'b0;
                budget = 0;
                while (!bus.tx_ready && budget < 100) begin tick(); budget++; end
                chk("stall_tx_ready_wait", budget < 100, 1);
                bad = 0;
                for (int k = 0; k < stall_len; k++) begin
                    if (bus.spi_start !== 1'b0 || bus.cs_n !== 1'b0 || bus.cmd_ready !== 1'b0)
                        bad++;
                    tick();
                end
                chk("stall_quiet", bad, 0);
                bus.tx_valid = 1'b1;
            end
            budget = 0;
            while (!bus.tx_ready && budget < 100) begin tick(); budget++; end
            chk("tx_ready_wait", budget < 100, 1);
            t = cyc;
            hs.push_back(t);
            if (i == 0) chk("setup_latency", t, e + 1 + S);
            else if (i == stall_at) chk("stall_resume", t, hs[i-1] + 35 + stall_len);
            else chk("byte_period", t, hs[i-1] + 35);
            tick();
            if (i + 1 < len) bus.tx_data = pat[i+1];
            else bus.tx_valid = 1'b0;
        end
        budget = 0;
        while (done_n == dn0 && budget < 200) begin tick(); budget++; end
        chk("done_wait", budget < 200, 1);
        budget = 0;
        while (!bus.cmd_ready && budget < 200) begin tick(); budget++; end
        chk("cmd_ready_wait", budget < 200, 1);
        rdy_c  = cyc;
        last_r = hs[len-1] + 35;
        nrx    = rxq_d.size() - rx0;
        chk("rx_count", nrx, len);
        for (int i = 0; i < len && i < nrx; i++) begin
            chk("rx_data", rxq_d[rx0+i], pat[i] ^ eng_key);
            chk("rx_timing", rxq_c[rx0+i], hs[i] + 35);
        end
        chk("done_count", done_n - dn0, 1);
        chk("done_timing", done_c, last_r + H);
        chk("cs_rise_count", rise_n - rs0, 1);
        chk("cs_fall_count", fall_n - fl0, 1);
        chk("cs_rise_timing", rise_c, last_r + H);
        chk("cmd_ready_timing", rdy_c, last_r + H + I);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, t, budget, bad, rx0, dn0, st0, rs0, fl0, len, sa;
        bus.cmd_valid = 1'b0;
        bus.cmd_len   = '0;
        bus.tx_valid  = 1'b0;
        bus.tx_data   = '0;
        tick(); tick();
        chk("rst_cs_n", bus.cs_n, 1);
        chk("rst_spi_start", bus.spi_start, 0);
        chk("rst_spi_din", bus.spi_din, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_tx_ready", bus.tx_ready, 0);
        reset_n = 1'b1;
        tick();
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // Single byte loopback.
        eng_key = 8'h00;
        pat = {8'hA5};
        do_xfer(1, -1, 0);

        // Back-to-back bytes.
        pat = {8'h01, 8'h80, 8'hFF};
        do_xfer(3, -1, 0);

        // Upstream stall before the second byte.
        pat = {8'h3C, 8'hC3};
        do_xfer(2, 1, 100);

        // Zero length.
        rx0 = rxq_d.size(); dn0 = done_n; st0 = start_n; rs0 = rise_n; fl0 = fall_n;
        bus.cmd_len   = '0;
        bus.cmd_valid = 1'b1;
        budget = 0;
        while (!bus.cmd_ready && budget < 200) begin tick(); budget++; end
        chk("zero_accept_wait", budget < 200, 1);
        tick();
        bus.cmd_valid = 1'b0;
        chk("zero_done_pulse", bus.done, 1);
        chk("zero_cmd_ready", bus.cmd_ready, 1);
        tick();
        chk("zero_done_end", bus.done, 0);
        repeat (10) tick();
        chk("zero_done_count", done_n - dn0, 1);
        chk("zero_no_rx", rxq_d.size() - rx0, 0);
        chk("zero_no_start", start_n - st0, 0);
        chk("zero_no_cs", (rise_n - rs0) + (fall_n - fl0), 0);

        // Reset ten cycles into a byte.
        pat = {8'h5A, 8'h96};
        bus.cmd_len   = LW'(2);
        bus.cmd_valid = 1'b1;
        budget = 0;
        while (!bus.cmd_ready && budget < 200) begin tick(); budget++; end
        tick();
        bus.cmd_valid = 1'b0;
        bus.tx_data   = pat[0];
        bus.tx_valid  = 1'b1;
        budget = 0;
        while (!bus.tx_ready && budget < 100) begin tick(); budget++; end
        chk("rst_test_tx_wait", budget < 100, 1);
        t = cyc;
        tick();
        bus.tx_valid = 1'b0;
        while (cyc < t + 10) tick();
        rx0 = rxq_d.size(); dn0 = done_n;
        reset_n = 1'b0;
        #1;
        chk("midrst_cs_n", bus.cs_n, 1);
        chk("midrst_spi_start", bus.spi_start, 0);
        chk("midrst_rx_data", bus.rx_data, 0);
        chk("midrst_engine_busy", eng_busy, 1);
        repeat (3) tick();
        reset_n = 1'b1;
        bad = 0;
        budget = 0;
        while (eng_busy && budget < 100) begin
            if (bus.cmd_ready !== 1'b0) bad++;
            tick();
            budget++;
        end
        chk("drain_wait", budget < 100, 1);
        chk("drain_cmd_ready_low", bad, 0);
        chk("drain_cmd_ready_up", bus.cmd_ready, 1);
        repeat (5) tick();
        chk("midrst_no_rx", rxq_d.size() - rx0, 0);
        chk("midrst_no_done", done_n - dn0, 0);
        do_xfer(2, -1, 0);

        // Randomized transactions with non-trivial engine response.
        for (int n = 0; n < 8; n++) begin
            eng_key = 8'($urandom);
            len = int'($urandom_range(1, 6));
            pat = {};
            for (int i = 0; i < len; i++) pat.push_back(8'($urandom));
            sa = (len > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : -1;
            do_xfer(len, sa, int'($urandom_range(1, 60)));
        end

        // Max length, incrementing data.
        eng_key = 8'h00;
        pat = {};
        for (int i = 0; i < 255; i++) pat.push_back(8'(i));
        do_xfer(255, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
